// File: rtl/enc_pkg.sv
// Shared constants, types and popcount helper for the 32-to-5 request encoder.
package enc_pkg;

  localparam int N     = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 6;

  typedef logic [N-1:0]     req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t popcount(input req_vec_t v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/req_encoder_32_to_5_rr_priority_pick.sv
// Rotating-start find-first-set over 32 lines; start=0 gives plain lowest-index priority.
module rr_priority_pick
  import enc_pkg::*;
(
  input  req_vec_t cand,
  input  idx_t     start,
  output idx_t     idx,
  output logic     any_set
);

  logic [2*N-1:0] dbl_s;
  logic [2*N-1:0] mask_s;
  logic [2*N-1:0] masked_s;
  idx_t           pos_s;

  // Lines below start are masked in the lower copy; the upper copy supplies the wrap-around.
  always_comb begin
    dbl_s    = {cand, cand};
    mask_s   = ~(({{(2*N-1){1'b0}}, 1'b1} << start) - {{(2*N-1){1'b0}}, 1'b1});
    masked_s = dbl_s & mask_s;
    pos_s    = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked_s[i]) begin
        pos_s = i[IDX_W-1:0];
      end else begin
        pos_s = pos_s;
      end
    end
    idx     = pos_s;
    any_set = |cand;
  end

endmodule

// File: rtl/req_encoder_32_to_5.sv
// Sticky 32-line request register served one index per handshake as a 5-bit code.
// Optional macro ROUND_ROBIN_EN selects rotating priority instead of lowest-index-first.
module req_encoder_32_to_5
  import enc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [N-1:0]      req_in,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  input  logic              out_ready,
  output logic [N-1:0]      pending,
  output logic [CNT_W-1:0]  pending_cnt
);

  req_vec_t pending_q, pending_d;
  logic     out_valid_q, out_valid_d;
  idx_t     out_idx_q, out_idx_d;
  cnt_t     cnt_q, cnt_d;

  req_vec_t cap_s;
  req_vec_t clr_s;
  req_vec_t cand_s;
  logic     hs_s;
  idx_t     start_s;
  idx_t     pick_idx_s;
  logic     pick_any_s;

`ifdef ROUND_ROBIN_EN
  idx_t     ptr_q, ptr_d;
`endif

  // Next pending vector; a same-cycle re-request overrides the clear of the accepted line.
  always_comb begin
    if (en) begin
      cap_s = req_in;
    end else begin
      cap_s = '0;
    end
    hs_s = out_valid_q && out_ready;
    if (hs_s) begin
      clr_s = {{(N-1){1'b0}}, 1'b1} << out_idx_q;
    end else begin
      clr_s = '0;
    end
    cand_s    = (pending_q & ~clr_s) | cap_s;
    pending_d = cand_s;
    cnt_d     = popcount(cand_s);
`ifdef ROUND_ROBIN_EN
    // Search from the post-handshake pointer so back-to-back picks rotate immediately.
    if (hs_s) begin
      ptr_d = out_idx_q + idx_t'(1);
    end else begin
      ptr_d = ptr_q;
    end
    start_s = ptr_d;
`else
    start_s = '0;
`endif
  end

  rr_priority_pick u_pick (
    .cand    (cand_s),
    .start   (start_s),
    .idx     (pick_idx_s),
    .any_set (pick_any_s)
  );

  // Output slot reloads when empty or when its current index is being accepted.
  always_comb begin
    if (!out_valid_q || hs_s) begin
      out_valid_d = pick_any_s;
      if (pick_any_s) begin
        out_idx_d = pick_idx_s;
      end else begin
        out_idx_d = out_idx_q;
      end
    end else begin
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      cnt_q       <= '0;
`ifdef ROUND_ROBIN_EN
      ptr_q       <= '0;
`endif
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      cnt_q       <= cnt_d;
`ifdef ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign pending     = pending_q;
  assign out_valid   = out_valid_q;
  assign out_idx     = out_idx_q;
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_req_encoder_32_to_5.sv
// Directed self-checking bench for req_encoder_32_to_5.
module tb_req_encoder_32_to_5;

  logic        clk;
  logic        reset;
  logic        en;
  logic [31:0] req_in;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic        out_ready;
  logic [31:0] pending;
  logic [5:0]  pending_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  req_encoder_32_to_5 dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req_in      (req_in),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .out_ready   (out_ready),
    .pending     (pending),
    .pending_cnt (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    req_in = 32'h0;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_idx;
    reset = 1'b1;
    en = 1'b1;
    req_in = 32'hFFFF_FFFF;
    out_ready = 1'b0;

    // 1. Reset overrides a full capture, then all 32 lines drain in order.
    step();
    check_val("rst_pending", pending, 32'h0);
    check_val("rst_valid", {31'h0, out_valid}, 32'h0);
    check_val("rst_cnt", {26'h0, pending_cnt}, 32'h0);
    check_val("rst_idx", {27'h0, out_idx}, 32'h0);
    reset = 1'b0;
    step();
    check_val("cap_all_pending", pending, 32'hFFFF_FFFF);
    check_val("cap_all_cnt", {26'h0, pending_cnt}, 32'd32);
    check_val("cap_all_idx", {27'h0, out_idx}, 32'd0);
    en = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      check_val("drain_cnt", {26'h0, pending_cnt}, 32'(32 - k));
      if (k < 32) begin
        check_val("drain_idx", {27'h0, out_idx}, 32'(k));
        check_val("drain_valid", {31'h0, out_valid}, 32'h1);
      end
    end
    check_val("drain_end_valid", {31'h0, out_valid}, 32'h0);
    check_val("drain_end_idx_hold", {27'h0, out_idx}, 32'd31);
    check_val("drain_end_pending", pending, 32'h0);

    // 2. Single request on line 25.
    en = 1'b1;
    req_in = 32'h0200_0000;
    step();
    check_val("single_valid", {31'h0, out_valid}, 32'h1);
    check_val("single_idx", {27'h0, out_idx}, 32'd25);
    check_val("single_cnt", {26'h0, pending_cnt}, 32'd1);
    en = 1'b0;
    req_in = 32'h0;
    step();
    check_val("single_done_valid", {31'h0, out_valid}, 32'h0);
    check_val("single_done_pending", pending, 32'h0);

    // 3. Stall with three lines pending, then release.
    do_reset();
    en = 1'b1;
    req_in = 32'h8000_1001;
    step();
    en = 1'b0;
    req_in = 32'h0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      check_val("stall_idx", {27'h0, out_idx}, 32'd0);
      check_val("stall_valid", {31'h0, out_valid}, 32'h1);
      check_val("stall_cnt", {26'h0, pending_cnt}, 32'd3);
    end
    out_ready = 1'b1;
    step();
    check_val("rel_idx12", {27'h0, out_idx}, 32'd12);
    check_val("rel_cnt2", {26'h0, pending_cnt}, 32'd2);
    step();
    check_val("rel_idx31", {27'h0, out_idx}, 32'd31);
    check_val("rel_cnt1", {26'h0, pending_cnt}, 32'd1);
    step();
    check_val("rel_empty", {31'h0, out_valid}, 32'h0);
    check_val("rel_cnt0", {26'h0, pending_cnt}, 32'd0);

    // 4. en gating.
    en = 1'b0;
    req_in = 32'h0004_0000;
    step();
    check_val("gate_valid", {31'h0, out_valid}, 32'h0);
    check_val("gate_pending", pending, 32'h0);
    en = 1'b1;
    step();
    check_val("gate_on_idx", {27'h0, out_idx}, 32'd18);
    check_val("gate_on_valid", {31'h0, out_valid}, 32'h1);
    en = 1'b0;
    req_in = 32'h0;
    step();
    check_val("gate_done", {31'h0, out_valid}, 32'h0);

    // 5. Line 12 re-requested on its own handshake edge stays pending.
    do_reset();
    en = 1'b1;
    req_in = 32'h0010_1000;
    step();
    check_val("coll_idx", {27'h0, out_idx}, 32'd12);
    req_in = 32'h0000_1000;
    out_ready = 1'b1;
    step();
    check_val("coll_pending", pending, 32'h0010_1000);
    check_val("coll_cnt", {26'h0, pending_cnt}, 32'd2);
    en = 1'b0;
    req_in = 32'h0;
    step();
    check_val("coll_cnt1", {26'h0, pending_cnt}, 32'd1);
    step();
    check_val("coll_pending_end", pending, 32'h0);
    check_val("coll_valid_end", {31'h0, out_valid}, 32'h0);

    // 6. Lines 1 and 31 requested continuously.
    do_reset();
    en = 1'b1;
    req_in = 32'h8000_0002;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
`ifdef ROUND_ROBIN_EN
      exp_idx = (k % 2 == 0) ? 5'd1 : 5'd31;
`else
      exp_idx = 5'd1;
`endif
      check_val("cont_idx", {27'h0, out_idx}, {27'h0, exp_idx});
      check_val("cont_pending", pending, 32'h8000_0002);
    end
    en = 1'b0;
    req_in = 32'h0;
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/req_encoder_32_to_5.md
Name: req_encoder_32_to_5

Overview:
- Sequential 32-to-5 request encoder: the inverse of the 5-to-32 write-select decoder.
- Captures a 32-bit one-hot/multi-hot request vector into a pending register.
- Presents one pending index at a time as a 5-bit code on a valid/ready handshake.
- Serves the processor's completion/interrupt paths, e.g. per-register writeback-done flags, converting them back to a register number for the consumer.

Parameters:
- N, 32, number of request lines. Fixed at 32 for this revision.
- IDX_W, 5, width of the encoded index; equals log2(N).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when 0, req_in is ignored that cycle.
- req_in  input  32  request bits; each 1 marks line i as pending (sticky until served).
- out_valid  output  1  out_idx holds a pending request.
- out_idx  output  5  encoded index of the presented request.
- out_ready  input  1  consumer accepts out_idx when out_valid && out_ready.
- pending  output  32  current pending-request register, for debug/status.
- pending_cnt  output  6  population count of pending, range 0..32.

Behaviour:
- Reset: one clock, synchronous, active-high. On the reset edge, pending=0, out_valid=0, out_idx=0, pending_cnt=0 and the round-robin pointer=0. Reset overrides en, req_in and any handshake in the same cycle.
- Capture mask: cap = en ? req_in : 0.
- Handshake: hs = out_valid && out_ready.
- Clear mask: clr = hs ? (1 << out_idx) : 0.
- Pending update each edge: pending <= (pending & ~clr) | cap.
  - If a bit is set and cleared in the same cycle, set wins and the bit stays pending.
- Output slot load condition: (!out_valid || hs).
- When the slot loads:
  - cand = (pending & ~clr) | cap.
  - out_valid <= |cand.
  - out_idx <= pick(cand).
  - When cand==0, out_idx holds its previous value.
- When the slot does not load (out_valid && !out_ready), out_valid and out_idx hold stable.
  - The presented bit stays set in pending until accepted.
- Latency:
  - A request on an idle block appears on out_valid/out_idx one edge after capture.
  - Back-to-back handshakes give one index per cycle; there are no bubbles while cand is nonzero.
- pick() without ROUND_ROBIN_EN: fixed priority, lowest set index wins.
- pending_cnt is registered alongside pending and equals popcount of the new pending value.
- The presented request counts as pending until its handshake edge.
- Boundaries:
  - All 32 bits set: 32 consecutive accepted handshakes drain to 0, with pending_cnt stepping 32..0.
  - Index 31 and index 0 both encode correctly.
  - There is no overflow: re-requesting a pending bit is idempotent.
  - en=0 with req_in nonzero: no capture; service of the existing pending bits continues.

Optional Feature:
- ROUND_ROBIN_EN defined:
  - pick() starts searching at pointer ptr (5-bit) and scans upward, wrapping 31 to 0.
  - On each handshake, ptr <= out_idx + 1, with 31 wrapping to 0.
  - Reset sets ptr=0.
  - A line that re-requests continuously cannot starve the others.
- ROUND_ROBIN_EN undefined: fixed lowest-index priority, and no ptr register exists.

Decomposition:
- Shared package enc_pkg holds:
  - constants N=32, IDX_W=5, CNT_W=6;
  - typedef req_vec_t (logic [N-1:0]);
  - typedef idx_t (logic [IDX_W-1:0]).
- One sub-module, rr_priority_pick (purely combinational):
  - Inputs: cand[31:0] and start[4:0].
  - Outputs: idx[4:0] and any_set.
  - Implemented as a double-width mask-and-find-first.
  - With start tied to 0, it degenerates to the fixed-priority encoder.
- The top level holds the pending register, the output slot, the pointer and the popcount.

Test Plan:
1. Reset with req_in=32'hFFFFFFFF, en=1 asserted the same cycle -> after the edge pending=0, out_valid=0, pending_cnt=0. On the first edge after reset deasserts, all 32 bits are captured and pending_cnt=32.
2. Single request: en=1, req_in=32'h0200_0000 for one cycle, out_ready=1 -> next cycle out_valid=1, out_idx=25. The cycle after that, out_valid=0 and pending=0.
3. Stall: req_in=32'h8000_1001, out_ready=0 for 5 cycles -> out_idx=0 held stable and pending_cnt=3. Raising out_ready then yields 0,12,31 in consecutive cycles (lowest-first, or the same order with ROUND_ROBIN_EN and ptr=0).
4. en gating: en=0, req_in=32'h0004_0000 -> no capture and out_valid stays 0. Then en=1 -> out_idx=18 on the following cycle.
5. Set/clear collision: while out_idx=12 is being accepted, req_in bit 12 is reasserted -> bit 12 stays in pending and is presented again later.
6. ROUND_ROBIN_EN: bits 1 and 31 requested continuously, out_ready=1 -> out_idx alternates 1,31,1,31 and ptr wraps 0 after serving 31. Without the macro, out_idx=1 is repeated.
